// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR period monitor: sample width, period width
// and the monitor FSM state encoding.
package lfsr_pkg;
    localparam int LFSR_WIDTH = 16;
    localparam int PERIOD_W   = LFSR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } monitor_state_t;
endpackage

// File: rtl/lfsr_period_monitor_if.sv
// Sample stream in, measurement status and results out, for the period monitor.
interface lfsr_period_monitor_if
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH
);
    logic             start;
    logic             sample_valid;
    logic [WIDTH-1:0] sample;
    logic             busy;
    logic             done;
    logic             repeated;
    logic             zero_lock;
    logic [WIDTH:0]   period;

    modport master (
        output start, sample_valid, sample,
        input  busy, done, repeated, zero_lock, period
    );

    modport slave (
        input  start, sample_valid, sample,
        output busy, done, repeated, zero_lock, period
    );
endinterface

// File: rtl/lfsr_period_monitor_period_counter.sv
// WIDTH+1 bit sample counter with synchronous clear/enable; o_nxt is the
// count the current sample would give, o_term flags that it equals MAX_COUNT.
module period_counter
    import lfsr_pkg::*;
#(
    parameter int WIDTH     = LFSR_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH
) (
    input  logic           clk,
    input  logic           i_clr,
    input  logic           i_en,
    output logic [WIDTH:0] o_nxt,
    output logic           o_term
);
    localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MAX_COUNT);

    logic [WIDTH:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_nxt;
        end
    end

    // One bit wider than the sample, so MAX_COUNT is reachable without wrap.
    assign o_nxt  = r_cnt + 1'b1;
    assign o_term = (o_nxt == MAX_C);
endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR sample stream: captures a
// reference sample, counts valid samples until it recurs or MAX_COUNT elapses.
module lfsr_period_monitor
    import lfsr_pkg::*;
#(
    parameter int WIDTH     = LFSR_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    lfsr_period_monitor_if.slave  bus
);
    localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MAX_COUNT);

    monitor_state_t   r_state;
    monitor_state_t   w_state_nxt;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH:0]   r_period;
    logic             r_repeated;
    logic             r_zero_lock;

    logic             w_match;
    logic [WIDTH:0]   w_nxt;
    logic             w_term;
    logic             w_cap_ref;
    logic             w_cnt_en;
    logic             w_finish;
    logic             w_res_clr;

    assign w_match = (bus.sample == r_ref);

    period_counter #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_period_counter (
        .clk    (clk),
        .i_clr  (reset | w_cap_ref),
        .i_en   (w_cnt_en),
        .o_nxt  (w_nxt),
        .o_term (w_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap_ref   = 1'b0;
        w_cnt_en    = 1'b0;
        w_finish    = 1'b0;
        w_res_clr   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (bus.sample_valid) begin
                    w_cap_ref   = 1'b1;
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // A match wins over the timeout on the same sample.
                if (bus.sample_valid) begin
                    if (w_match || w_term) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_res_clr   = 1'b1;
                    w_state_nxt = ST_ARM;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref       <= '0;
            r_period    <= '0;
            r_repeated  <= 1'b0;
            r_zero_lock <= 1'b0;
        end else begin
            if (w_cap_ref) begin
                r_ref       <= bus.sample;
                r_zero_lock <= (bus.sample == '0);
            end
            if (w_finish) begin
                r_period   <= w_match ? w_nxt : MAX_C;
                r_repeated <= w_match;
            end
            if (w_res_clr) begin
                r_period    <= '0;
                r_repeated  <= 1'b0;
                r_zero_lock <= 1'b0;
            end
        end
    end

    assign bus.busy      = (r_state == ST_ARM) || (r_state == ST_COUNT);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.repeated  = r_repeated;
    assign bus.zero_lock = r_zero_lock;
    assign bus.period    = r_period;
endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Bench for lfsr_period_monitor: a 16-bit and a 4-bit instance, directed
// scenarios plus random traffic, checked every cycle against a reference model.
module tb_lfsr_period_monitor;
    import lfsr_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    bit   chk_en;

    lfsr_period_monitor_if #(.WIDTH(16)) bus16();
    lfsr_period_monitor_if #(.WIDTH(4))  bus4();

    lfsr_period_monitor u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    lfsr_period_monitor #(
        .WIDTH     (4),
        .MAX_COUNT (16)
    ) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 waiting for reference, 2 measuring, 3 finished.
    typedef struct {
        int phase;
        int refv;
        int seen;
        int period;
        bit rep;
        bit zl;
    } model_t;

    model_t m16;
    model_t m4;

    function automatic model_t mstep(model_t m, logic rst, logic st, logic v,
                                     int s, int maxc);
        model_t r;
        r = m;
        if (rst) begin
            r.phase = 0; r.refv = 0; r.seen = 0; r.period = 0; r.rep = 0; r.zl = 0;
        end else if (m.phase == 0) begin
            if (st) r.phase = 1;
        end else if (m.phase == 1) begin
            if (v) begin
                r.refv  = s;
                r.seen  = 0;
                r.zl    = (s == 0);
                r.phase = 2;
            end
        end else if (m.phase == 2) begin
            if (v) begin
                r.seen = m.seen + 1;
                if (s == m.refv) begin
                    r.period = r.seen; r.rep = 1; r.phase = 3;
                end else if (r.seen == maxc) begin
                    r.period = maxc; r.rep = 0; r.phase = 3;
                end
            end
        end else begin
            if (st) begin
                r.period = 0; r.rep = 0; r.zl = 0; r.phase = 1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] expv(model_t m);
        logic [16:0] p;
        p = 17'(m.period);
        return {11'b0, (m.phase == 1 || m.phase == 2), (m.phase == 3), m.rep, m.zl, p};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m16 = mstep(m16, reset, bus16.start, bus16.sample_valid, int'(bus16.sample), 65536);
        m4  = mstep(m4, reset, bus4.start, bus4.sample_valid, int'(bus4.sample), 16);
        if (reset) chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model16", {11'b0, bus16.busy, bus16.done, bus16.repeated,
                            bus16.zero_lock, bus16.period}, expv(m16));
            chk("model4", {11'b0, bus4.busy, bus4.done, bus4.repeated,
                           bus4.zero_lock, 12'b0, bus4.period}, expv(m4));
        end
    end

    task automatic c16(bit st, bit v, logic [15:0] s);
        bus16.start        = st;
        bus16.sample_valid = v;
        bus16.sample       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic c4(bit st, bit v, logic [3:0] s);
        bus4.start        = st;
        bus4.sample_valid = v;
        bus4.sample       = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] seq [6];
        logic [15:0] lf;
        int          k;

        n_chk  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        m16    = '{0, 0, 0, 0, 0, 0};
        m4     = '{0, 0, 0, 0, 0, 0};
        seq    = '{16'd3, 16'd7, 16'd9, 16'd1, 16'd4, 16'd3};
        bus16.start = 1'b0; bus16.sample_valid = 1'b0; bus16.sample = '0;
        bus4.start  = 1'b0; bus4.sample_valid  = 1'b0; bus4.sample  = '0;
        reset = 1'b1;
        #1;
        c16(0, 0, 0);
        c16(0, 0, 0);
        reset = 1'b0;
        chk("rst_busy", 32'(bus16.busy), 32'd0);
        chk("rst_done", 32'(bus16.done), 32'd0);
        chk("rst_period", 32'(bus16.period), 32'd0);

        // Basic repeat: 3 7 9 1 4 3
        c16(1, 0, 0);
        chk("arm_busy", 32'(bus16.busy), 32'd1);
        foreach (seq[i]) begin
            if (i == 5) chk("pre_done", 32'(bus16.done), 32'd0);
            c16(0, 1, seq[i]);
        end
        chk("basic_done", 32'(bus16.done), 32'd1);
        chk("basic_busy", 32'(bus16.busy), 32'd0);
        chk("basic_period", 32'(bus16.period), 32'd5);
        chk("basic_rep", 32'(bus16.repeated), 32'd1);
        chk("basic_zl", 32'(bus16.zero_lock), 32'd0);

        // Same sequence with gaps; start from DONE clears results
        c16(1, 0, 0);
        chk("restart_period", 32'(bus16.period), 32'd0);
        chk("restart_rep", 32'(bus16.repeated), 32'd0);
        foreach (seq[i]) begin
            c16(0, 0, 16'($urandom));
            c16(0, 1, seq[i]);
        end
        chk("gap_done", 32'(bus16.done), 32'd1);
        chk("gap_period", 32'(bus16.period), 32'd5);

        // All-zero reference
        c16(1, 0, 0);
        c16(0, 1, 0);
        c16(0, 1, 0);
        chk("zero_period", 32'(bus16.period), 32'd1);
        chk("zero_rep", 32'(bus16.repeated), 32'd1);
        chk("zero_zl", 32'(bus16.zero_lock), 32'd1);

        // start mid-COUNT is ignored
        c16(1, 0, 0);
        c16(0, 1, 10);
        c16(0, 1, 11);
        c16(1, 1, 12);
        c16(0, 1, 13);
        c16(0, 1, 10);
        chk("ign_start_period", 32'(bus16.period), 32'd4);

        // reset mid-COUNT, then a fresh measurement
        c16(1, 0, 0);
        c16(0, 1, 20);
        c16(0, 1, 21);
        reset = 1'b1;
        c16(0, 1, 20);
        reset = 1'b0;
        chk("midrst_busy", 32'(bus16.busy), 32'd0);
        chk("midrst_done", 32'(bus16.done), 32'd0);
        chk("midrst_period", 32'(bus16.period), 32'd0);
        c16(1, 0, 0);
        c16(0, 1, 42);
        c16(0, 1, 1);
        c16(0, 1, 42);
        chk("after_rst_period", 32'(bus16.period), 32'd2);

        // 4-bit instance: timeout, then match on the timeout sample
        c4(1, 0, 0);
        c4(0, 1, 5);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) chk("to_pre_done", 32'(bus4.done), 32'd0);
            c4(0, 1, 6);
        end
        chk("to_done", 32'(bus4.done), 32'd1);
        chk("to_period", 32'(bus4.period), 32'd16);
        chk("to_rep", 32'(bus4.repeated), 32'd0);
        c4(1, 0, 0);
        c4(0, 1, 5);
        for (int i = 1; i <= 16; i++) c4(0, 1, (i == 16) ? 4'd5 : 4'd6);
        chk("prio_period", 32'(bus4.period), 32'd16);
        chk("prio_rep", 32'(bus4.repeated), 32'd1);

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            bus4.start        = ($urandom_range(0, 7) == 0);
            bus4.sample_valid = ($urandom_range(0, 3) != 0);
            bus4.sample       = 4'($urandom_range(0, 15));
            c16(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                16'($urandom_range(0, 7)));
        end
        bus4.start = 1'b0; bus4.sample_valid = 1'b0;

        // Maximal-length LFSR seeded 0x0001
        reset = 1'b1;
        c16(0, 0, 0);
        reset = 1'b0;
        c16(1, 0, 0);
        lf = 16'h0001;
        k  = 0;
        while (bus16.done !== 1'b1 && k < 70000) begin
            c16(0, 1, lf);
            lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
            k++;
        end
        chk("lfsr_done_in_bound", 32'(bus16.done), 32'd1);
        chk("lfsr_period", 32'(bus16.period), 32'd65535);
        chk("lfsr_rep", 32'(bus16.repeated), 32'd1);
        chk("lfsr_valid_cycles", 32'(k), 32'd65536);
        c16(0, 0, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/lfsr_period_monitor.md
# lfsr_period_monitor

- Downstream consumer of the 16-bit LFSR state register (the `lfsr` + `flop` loop); watches the sample stream it produces.
- On `start`, captures one sample as the reference, then counts valid samples until the reference value recurs or a timeout is reached.
- Reports the measured period, a repeat flag and an all-zero lock-up flag.
- Used in hardware self-test in place of bench-side period checking.

## Interface
- `WIDTH`, 16: sample width in bits.
- `MAX_COUNT`, 2**WIDTH: timeout, the number of post-reference samples after which measurement ends without a repeat.
- `clk`  in  1: single clock; everything is updated on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a measurement; honoured only in IDLE or DONE.
- `sample_valid`  in  1: `sample` is meaningful this cycle.
- `sample`  in  WIDTH: LFSR state (flop Q output).
- `busy`  out  1: high in ARM and COUNT.
- `done`  out  1: high in DONE; results are stable while high.
- `repeated`  out  1: the reference value recurred before timeout.
- `zero_lock`  out  1: the reference sample was all-zero.
- `period`  out  WIDTH+1: number of valid samples from the reference to the match, or MAX_COUNT on timeout.

## Operation
- States: IDLE, ARM, COUNT, DONE.
- IDLE, on `start`: go to ARM.
- ARM, on `sample_valid`:
  - `ref` <= `sample`; `cnt` <= 0.
  - `zero_lock` <= (`sample` == 0).
  - Go to COUNT.
- COUNT, on `sample_valid`, with `nxt` = `cnt` + 1 (WIDTH+1 bits, cannot overflow):
  - If `sample` == `ref`: `period` <= `nxt`, `repeated` <= 1, go to DONE.
  - Else if `nxt` == MAX_COUNT: `period` <= MAX_COUNT, `repeated` <= 0, go to DONE.
  - Else: `cnt` <= `nxt`.
  - A match takes priority over the timeout on the same sample.
- Cycles with `sample_valid` = 0 are ignored in ARM and COUNT. No state change, no count.
- DONE: hold all results.
  - `start` clears `period`, `repeated` and `zero_lock`, and goes to ARM.
- `start` in ARM or COUNT is ignored. There is no abort other than `reset`.
- All outputs are registered. `busy` and `done` are decoded from state registers only.
- Reset (any state, including mid-COUNT): next edge gives state IDLE; `busy`, `done`, `repeated`, `zero_lock` = 0; `period` = 0; `ref` and `cnt` = 0.

## Timing
- `start` sampled at edge N gives `busy` = 1 after N.
- Reference captured at the first edge ≥ N+1 where `sample_valid` = 1.
- Matching or timeout sample at edge M gives, after M, `done` = 1, `busy` = 0 and final `period`/`repeated`. Latency is one edge.
- `done` stays high until the edge that samples `start` or `reset`.
- A 0→1 `busy` to `done` sequence never overlaps: exactly one of `busy` and `done` is high outside IDLE.
- For a maximal-length 16-bit LFSR with a nonzero seed, the expected result is `period` = 65535 and `repeated` = 1. Measurement takes 65536 valid cycles after ARM.

## Structure
- Shared package `lfsr_pkg`:
  - `LFSR_WIDTH` = 16.
  - `monitor_state_t` enum (IDLE, ARM, COUNT, DONE).
  - `PERIOD_W` = `LFSR_WIDTH` + 1.
- Top-level `lfsr_period_monitor` holds the FSM and output registers.
- One sub-module: `period_counter`, a WIDTH+1 counter with clear/enable and a terminal flag at MAX_COUNT.
- The `ref` register is a plain enabled register inside the top-level.

## Test plan
- Start, then feed valid samples 3, 7, 9, 1, 4, 3 -> `done` after the edge of the second 3; `period` = 5, `repeated` = 1, `zero_lock` = 0.
- Same sequence with `sample_valid` low on alternate cycles -> identical results; `done` asserts one edge after the last valid 3.
- Feed 0, 0 -> `period` = 1, `repeated` = 1, `zero_lock` = 1.
- WIDTH = 4, MAX_COUNT = 16; feed ref 5, then 16 samples of 6 -> `done` after the 16th, `period` = 16, `repeated` = 0. With the 16th sample = 5 instead: `period` = 16, `repeated` = 1 (match priority).
- Connect to `lfsr` + `flop` loop seeded 0x0001 -> `period` = 65535, `repeated` = 1; `busy` high throughout.
- Pulse `start` mid-COUNT -> ignored, count continues. Assert `reset` mid-COUNT -> next edge all outputs 0, state IDLE. A later `start` measures correctly.
